// File: rtl/timer_job_scheduler_pkg.sv
// Shared types and helpers for the timer job scheduler: FSM state
// encoding and the round-robin pick used by the arbiter.
package timer_sched_pkg;

  // Widest requester vector the pick helper handles.
  localparam int MAX_REQ = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARM   = ST_ARM,
    START = ST_START,
    WAIT  = ST_WAIT,
    FIN   = ST_FIN
  } state_e;

  // First set bit of req searching upward from ptr+1, wrapping at n.
  // Returns 0 when nothing is set; callers qualify with |req.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int   win;
    int   idx;
    logic found;
    logic hit;
    win   = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx   = ptr + k;
      idx   = (idx >= n) ? idx - n : idx;
      hit   = (k <= n) && !found && req[idx[2:0]];
      win   = hit ? idx : win;
      found = found | hit;
    end
    return win;
  endfunction

endpackage

// File: rtl/timer_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: rotates priority so the requester
// after ptr is searched first. Holds no state; the pointer lives upstream.
module rr_arbiter
  import timer_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [MAX_REQ-1:0] req_ext_s;

  // Widen the request vector to the helper width and pick the winner.
  always_comb begin
    req_ext_s              = '0;
    req_ext_s[N_REQ-1:0]   = req;
    winner                 = ID_W'(rr_pick(req_ext_s, int'(ptr), N_REQ));
    any                    = |req;
  end

endmodule

// File: rtl/timer_job_scheduler.sv
// Round-robin scheduler sharing one hardware timer among N_REQ requesters.
// Each granted job arms the timer (reset pulse, then enable edge with the
// compare value), waits for match/overflow/cancel/watchdog, then reports.
module timer_job_scheduler
  import timer_sched_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int TIMER_WIDTH = 16,
  parameter  int WD_WIDTH    = 24,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*TIMER_WIDTH-1:0] req_delay,
  output logic [N_REQ-1:0]             done,
  output logic [N_REQ-1:0]             err,
  output logic                         grant_valid,
  output logic [ID_W-1:0]              grant_id,
  output logic [TIMER_WIDTH-1:0]       tmr_load,
  output logic                         tmr_enable,
  output logic                         tmr_reset,
  output logic [TIMER_WIDTH-1:0]       tmr_compare,
  input  logic                         tmr_match,
  input  logic                         tmr_overflow
);

  localparam logic [WD_WIDTH-1:0] WD_MAX = {WD_WIDTH{1'b1}};

  state_e                   state_r, nxt_state_s;
  logic [ID_W-1:0]          rr_r, nxt_rr_s;
  logic [TIMER_WIDTH-1:0]   delay_r, nxt_delay_s;
  logic [WD_WIDTH-1:0]      wd_r, nxt_wd_s, wd_inc_s;
  logic [N_REQ-1:0]         done_r, nxt_done_s, err_r, nxt_err_s;
  logic                     grant_valid_r, nxt_grant_valid_s;
  logic [ID_W-1:0]          grant_id_r, nxt_grant_id_s;
  logic [TIMER_WIDTH-1:0]   tmr_load_r, nxt_tmr_load_s;
  logic                     tmr_enable_r, nxt_tmr_enable_s;
  logic                     tmr_reset_r, nxt_tmr_reset_s;
  logic [TIMER_WIDTH-1:0]   tmr_compare_r, nxt_tmr_compare_s;
  logic [ID_W-1:0]          winner_s;
  logic                     any_s;
  logic [TIMER_WIDTH-1:0]   delay_slice_s;
  logic                     owner_req_s;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (req),
    .ptr    (rr_r),
    .winner (winner_s),
    .any    (any_s)
  );

  // Winner's delay slice, owner's live request, saturating watchdog step.
  always_comb begin
    delay_slice_s = req_delay[int'(winner_s)*TIMER_WIDTH +: TIMER_WIDTH];
    owner_req_s   = req[grant_id_r];
    wd_inc_s      = (wd_r == WD_MAX) ? wd_r : wd_r + 1'b1;
  end

  // Next-state and next-output logic; outputs are computed for the state
  // being entered so the registered values line up with that state.
  always_comb begin
    nxt_state_s       = state_r;
    nxt_rr_s          = rr_r;
    nxt_delay_s       = delay_r;
    nxt_wd_s          = wd_r;
    nxt_done_s        = '0;
    nxt_err_s         = '0;
    nxt_grant_valid_s = grant_valid_r;
    nxt_grant_id_s    = grant_id_r;
    nxt_tmr_load_s    = '0;
    nxt_tmr_enable_s  = 1'b0;
    nxt_tmr_reset_s   = 1'b0;
    nxt_tmr_compare_s = '0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          nxt_grant_valid_s = 1'b1;
          nxt_grant_id_s    = winner_s;
          nxt_rr_s          = winner_s;
          nxt_delay_s       = delay_slice_s;
          nxt_tmr_reset_s   = 1'b1;
          if (delay_slice_s == '0) begin
            // Zero delay completes without ever enabling the timer.
            nxt_state_s          = FIN;
            nxt_done_s[winner_s] = 1'b1;
          end else begin
            nxt_state_s = ARM;
          end
        end else begin
          nxt_grant_valid_s = 1'b0;
          nxt_grant_id_s    = '0;
        end
      end
      ARM: begin
        nxt_state_s       = START;
        nxt_tmr_enable_s  = 1'b1;
        nxt_tmr_compare_s = delay_r;
        nxt_wd_s          = '0;
      end
      START: begin
        nxt_state_s       = WAIT;
        nxt_tmr_enable_s  = 1'b1;
        nxt_tmr_compare_s = delay_r;
        nxt_wd_s          = '0;
      end
      WAIT: begin
        nxt_wd_s = wd_inc_s;
        if (!owner_req_s) begin
          nxt_state_s     = FIN;
          nxt_tmr_reset_s = 1'b1;
        end else if (tmr_match) begin
          nxt_state_s            = FIN;
          nxt_tmr_reset_s        = 1'b1;
          nxt_done_s[grant_id_r] = 1'b1;
        end else if (tmr_overflow || (wd_inc_s == WD_MAX)) begin
          nxt_state_s           = FIN;
          nxt_tmr_reset_s       = 1'b1;
          nxt_err_s[grant_id_r] = 1'b1;
        end else begin
          nxt_tmr_enable_s  = 1'b1;
          nxt_tmr_compare_s = delay_r;
        end
      end
      FIN: begin
        nxt_state_s       = IDLE;
        nxt_grant_valid_s = 1'b0;
        nxt_grant_id_s    = '0;
      end
      default: begin
        nxt_state_s       = IDLE;
        nxt_grant_valid_s = 1'b0;
        nxt_grant_id_s    = '0;
      end
    endcase
  end

  // State, pointer, watchdog and output registers with async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_r          <= ID_W'(N_REQ - 1);
      delay_r       <= '0;
      wd_r          <= '0;
      done_r        <= '0;
      err_r         <= '0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
      tmr_load_r    <= '0;
      tmr_enable_r  <= 1'b0;
      tmr_reset_r   <= 1'b0;
      tmr_compare_r <= '0;
    end else begin
      state_r       <= nxt_state_s;
      rr_r          <= nxt_rr_s;
      delay_r       <= nxt_delay_s;
      wd_r          <= nxt_wd_s;
      done_r        <= nxt_done_s;
      err_r         <= nxt_err_s;
      grant_valid_r <= nxt_grant_valid_s;
      grant_id_r    <= nxt_grant_id_s;
      tmr_load_r    <= nxt_tmr_load_s;
      tmr_enable_r  <= nxt_tmr_enable_s;
      tmr_reset_r   <= nxt_tmr_reset_s;
      tmr_compare_r <= nxt_tmr_compare_s;
    end
  end

  assign done        = done_r;
  assign err         = err_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;
  assign tmr_load    = tmr_load_r;
  assign tmr_enable  = tmr_enable_r;
  assign tmr_reset   = tmr_reset_r;
  assign tmr_compare = tmr_compare_r;

endmodule

// File: tb/tb_timer_job_scheduler.sv
// Self-checking bench for timer_job_scheduler. A job-level model predicts
// the winner (round-robin from the last owner), the phase sequence
// IDLE -> ARM -> START -> WAIT(n) -> FIN and the job outcome; the bench also
// plays the timer, raising tmr_match `delay` cycles after the enable edge.
module tb_timer_job_scheduler;

  localparam int N      = 4;
  localparam int TW     = 16;
  localparam int WD     = 4;
  localparam int WD_LIM = (1 << WD) - 1;  // WAIT cycles before the watchdog fires

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*TW-1:0] req_delay;
  logic [N-1:0]  done, err;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic [TW-1:0] tmr_load, tmr_compare;
  logic          tmr_enable, tmr_reset, tmr_match, tmr_overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int rr_m;  // model: index of the last granted requester

  timer_job_scheduler #(.N_REQ(N), .TIMER_WIDTH(TW), .WD_WIDTH(WD)) dut (
    .clk(clk), .rst(rst), .req(req), .req_delay(req_delay),
    .done(done), .err(err), .grant_valid(grant_valid), .grant_id(grant_id),
    .tmr_load(tmr_load), .tmr_enable(tmr_enable), .tmr_reset(tmr_reset),
    .tmr_compare(tmr_compare), .tmr_match(tmr_match), .tmr_overflow(tmr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gv"},  {31'd0, grant_valid}, 32'd0);
    chk({tag, "_gid"}, {30'd0, grant_id}, 32'd0);
    chk({tag, "_done"}, {28'd0, done}, 32'd0);
    chk({tag, "_err"},  {28'd0, err}, 32'd0);
    chk({tag, "_en"},  {31'd0, tmr_enable}, 32'd0);
    chk({tag, "_rst"}, {31'd0, tmr_reset}, 32'd0);
    chk({tag, "_cmp"}, {16'd0, tmr_compare}, 32'd0);
  endtask

  // One job from IDLE back to IDLE. cancel_at/ovf_at/rst_at name the WAIT
  // cycle (1-based) in which that event is applied; 0 means never.
  task automatic run_job(input logic [N-1:0] r, input logic [N*TW-1:0] dl,
                         input int cancel_at, input int ovf_at, input bit hold, input int rst_at);
    int win, idx, w, outcome;
    logic [TW-1:0] dly;
    logic [31:0] exp_bit;
    req = r;
    req_delay = dl;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (rr_m + k) % N;
      if (win < 0 && r[idx[1:0]]) win = idx;
    end
    if (win < 0) return;
    dly = dl[win*TW +: TW];
    exp_bit = 32'd1 << win;
    step();
    rr_m = win;
    chk("grant_valid", {31'd0, grant_valid}, 32'd1);
    chk("grant_id", {30'd0, grant_id}, win);
    req_delay = {$urandom, $urandom};  // must be ignored from here on
    if (dly == '0) begin
      chk("zd_done", {28'd0, done}, exp_bit);
      chk("zd_err", {28'd0, err}, 32'd0);
      chk("zd_en", {31'd0, tmr_enable}, 32'd0);
      if (!hold) req[win[1:0]] = 1'b0;
    end else begin
      chk("arm_rst", {31'd0, tmr_reset}, 32'd1);
      chk("arm_en", {31'd0, tmr_enable}, 32'd0);
      step();
      chk("start_en", {31'd0, tmr_enable}, 32'd1);
      chk("start_rst", {31'd0, tmr_reset}, 32'd0);
      chk("start_cmp", {16'd0, tmr_compare}, {16'd0, dly});
      chk("start_load", {16'd0, tmr_load}, 32'd0);
      step();
      w = 1;
      outcome = -1;
      while (outcome < 0) begin
        chk("wait_en", {31'd0, tmr_enable}, 32'd1);
        chk("wait_cmp", {16'd0, tmr_compare}, {16'd0, dly});
        chk("wait_pulse", {28'd0, done | err}, 32'd0);
        if (w == rst_at) begin
          #2 rst = 1'b1;
          #1;
          chk_quiet("async_rst");
          req = '0;
          @(posedge clk);
          #1 rst = 1'b0;
          rr_m = N - 1;
          return;
        end
        tmr_match    = (w == int'(dly));
        tmr_overflow = (w == ovf_at);
        if (w == cancel_at) req[win[1:0]] = 1'b0;
        if (w == cancel_at)         outcome = 0;
        else if (w == int'(dly))    outcome = 1;
        else if (w == ovf_at)       outcome = 2;
        else if (w == WD_LIM)       outcome = 2;
        step();
        tmr_match = 1'b0;
        tmr_overflow = 1'b0;
        w++;
      end
      chk("fin_done", {28'd0, done}, (outcome == 1) ? exp_bit : 32'd0);
      chk("fin_err", {28'd0, err}, (outcome == 2) ? exp_bit : 32'd0);
      chk("fin_en", {31'd0, tmr_enable}, 32'd0);
      chk("fin_rst", {31'd0, tmr_reset}, 32'd1);
      chk("fin_gv", {31'd0, grant_valid}, 32'd1);
      if (!hold) req[win[1:0]] = 1'b0;
    end
    step();
    chk("idle_gv", {31'd0, grant_valid}, 32'd0);
    chk("idle_en", {31'd0, tmr_enable}, 32'd0);
    chk("idle_pulse", {28'd0, done | err}, 32'd0);
  endtask

  initial begin
    logic [N-1:0]    r;
    logic [N*TW-1:0] dl;
    int ca, oa;
    rst = 1'b1;
    req = '0;
    req_delay = '0;
    tmr_match = 1'b0;
    tmr_overflow = 1'b0;
    rr_m = N - 1;
    #3;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fairness: all held, delay 2 each -> grants 0,1,2,3,0.
    for (int j = 0; j < 5; j++) run_job(4'b1111, {4{16'd2}}, 0, 0, 1'b1, 0);
    // Single job on requester 1, delay 5.
    run_job(4'b0010, {16'd0, 16'd0, 16'd5, 16'd0}, 0, 0, 1'b0, 0);
    // Zero delay on requester 2.
    run_job(4'b0100, {16'd0, 16'd0, 16'd0, 16'd0}, 0, 0, 1'b0, 0);
    // Cancel requester 3 during WAIT, then requester 0 goes next.
    run_job(4'b1001, {16'd100, 16'd0, 16'd0, 16'd3}, 5, 0, 1'b0, 0);
    run_job(4'b0001, {16'd0, 16'd0, 16'd0, 16'd3}, 0, 0, 1'b0, 0);
    // Match never arrives -> watchdog error.
    run_job(4'b0010, {16'd0, 16'd0, 16'd100, 16'd0}, 0, 0, 1'b0, 0);
    // Match and overflow together -> done.
    run_job(4'b0100, {16'd0, 16'd4, 16'd0, 16'd0}, 0, 4, 1'b0, 0);
    // Overflow alone -> error.
    run_job(4'b1000, {16'd10, 16'd0, 16'd0, 16'd0}, 0, 3, 1'b0, 0);
    // Owner drop in the match cycle -> cancel, no done.
    run_job(4'b0001, {16'd0, 16'd0, 16'd0, 16'd6}, 6, 0, 1'b0, 0);
    // Match in the same cycle the watchdog would fire -> done.
    run_job(4'b0010, {16'd0, 16'd0, 16'd15, 16'd0}, 0, 0, 1'b0, 0);
    // Async reset mid-WAIT on requester 2, then 0 must win over 3.
    run_job(4'b0100, {16'd0, 16'd100, 16'd0, 16'd0}, 0, 0, 1'b0, 4);
    run_job(4'b1001, {16'd1, 16'd0, 16'd0, 16'd1}, 0, 0, 1'b0, 0);

    // Randomized jobs.
    for (int j = 0; j < 40; j++) begin
      r = N'($urandom_range(1, 15));
      for (int s = 0; s < N; s++) dl[s*TW +: TW] = TW'($urandom_range(0, 18));
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      oa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 16)) : 0;
      run_job(r, dl, ca, oa, 1'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
